// File: rtl/axi_lite_mem_responder_pkg.sv
// Shared definitions for the AXI4-Lite memory responder: response codes and
// the write/read control state encodings.
package axi_lite_mem_responder_pkg;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic {W_IDLE, W_RESP} wstate_t;
    typedef enum logic {R_IDLE, R_DATA} rstate_t;
endpackage

// File: rtl/axi_lite_mem_responder_ram.sv
// Word-wide storage: one byte-enabled write port and one registered read port.
// A write and a read of the same word on the same edge reads the old value.
module axi_lite_dp_ram #(
    parameter int RAW   = 8,
    parameter int DEPTH = 256
) (
    input  logic            clk,
    input  logic            i_we,
    input  logic [RAW-1:0]  i_waddr,
    input  logic [31:0]     i_wdata,
    input  logic [3:0]      i_wbe,
    input  logic            i_re,
    input  logic [RAW-1:0]  i_raddr,
    output logic [31:0]     o_rdata
);
    logic [31:0] r_mem [DEPTH];
    logic [31:0] r_rdata;

    always_ff @(posedge clk) begin
        if (i_we) begin
            for (int b = 0; b < 4; b++) begin
                if (i_wbe[b]) r_mem[i_waddr][8*b +: 8] <= i_wdata[8*b +: 8];
            end
        end
        // Read register only loads on a new request so data holds under stall.
        if (i_re) r_rdata <= r_mem[i_raddr];
    end

    assign o_rdata = r_rdata;
endmodule

// File: rtl/axi_lite_mem_responder.sv
// AXI4-Lite memory responder: independent AW/W capture with single-outstanding
// write, and a latency-1 read path; out-of-range word indices return SLVERR.
module axi_lite_mem_responder
    import axi_lite_mem_responder_pkg::*;
#(
    parameter int AW    = 12,
    parameter int DEPTH = 256
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [AW-1:0] i_awaddr,
    input  logic          i_awvalid,
    output logic          o_awready,
    input  logic [31:0]   i_wdata,
    input  logic [3:0]    i_wstrb,
    input  logic          i_wvalid,
    output logic          o_wready,
    output logic [1:0]    o_bresp,
    output logic          o_bvalid,
    input  logic          i_bready,
    input  logic [AW-1:0] i_araddr,
    input  logic          i_arvalid,
    output logic          o_arready,
    output logic [31:0]   o_rdata,
    output logic [1:0]    o_rresp,
    output logic          o_rlast,
    output logic          o_rvalid,
    input  logic          i_rready
);
    localparam int             RAW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW-2:0]  IDX_LIM = (AW-1)'(DEPTH);

    wstate_t        r_wstate, w_wnext;
    rstate_t        r_rstate, w_rnext;
    logic           r_aw_held, r_w_held;
    logic [AW-1:0]  r_awaddr;
    logic [31:0]    r_wdata;
    logic [3:0]     r_wstrb;
    logic [1:0]     r_bresp, r_rresp;
    logic           r_roor;

    logic           w_awready, w_wready, w_arready, w_commit, w_rd;
    logic [AW-1:0]  w_awaddr_sel;
    logic [31:0]    w_wdata_sel, w_ram_rdata;
    logic [3:0]     w_wstrb_sel;
    logic [AW-3:0]  w_widx, w_ridx;
    logic           w_woor, w_roor;

    // The second of AW/W may arrive this cycle, so take it straight from the bus.
    assign w_awaddr_sel = r_aw_held ? r_awaddr : i_awaddr;
    assign w_wdata_sel  = r_w_held  ? r_wdata  : i_wdata;
    assign w_wstrb_sel  = r_w_held  ? r_wstrb  : i_wstrb;
    assign w_widx       = w_awaddr_sel[AW-1:2];
    assign w_ridx       = i_araddr[AW-1:2];
    assign w_woor       = {1'b0, w_widx} >= IDX_LIM;
    assign w_roor       = {1'b0, w_ridx} >= IDX_LIM;

    always_comb begin
        w_wnext   = r_wstate;
        w_awready = 1'b0;
        w_wready  = 1'b0;
        w_commit  = 1'b0;
        case (r_wstate)
            W_IDLE: begin
                w_awready = !rst && !r_aw_held;
                w_wready  = !rst && !r_w_held;
                if ((r_aw_held || (i_awvalid && w_awready)) &&
                    (r_w_held  || (i_wvalid  && w_wready))) begin
                    w_commit = 1'b1;
                    w_wnext  = W_RESP;
                end
            end
            W_RESP: if (i_bready) w_wnext = W_IDLE;
            default: w_wnext = W_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wstate  <= W_IDLE;
            r_aw_held <= 1'b0;
            r_w_held  <= 1'b0;
            r_bresp   <= RESP_OKAY;
        end else begin
            r_wstate <= w_wnext;
            if (i_awvalid && w_awready) begin
                r_aw_held <= 1'b1;
                r_awaddr  <= i_awaddr;
            end
            if (i_wvalid && w_wready) begin
                r_w_held <= 1'b1;
                r_wdata  <= i_wdata;
                r_wstrb  <= i_wstrb;
            end
            if (w_commit) r_bresp <= w_woor ? RESP_SLVERR : RESP_OKAY;
            if (r_wstate == W_RESP && i_bready) begin
                r_aw_held <= 1'b0;
                r_w_held  <= 1'b0;
            end
        end
    end

    always_comb begin
        w_rnext   = r_rstate;
        w_arready = 1'b0;
        w_rd      = 1'b0;
        case (r_rstate)
            R_IDLE: begin
                w_arready = !rst;
                w_rd      = i_arvalid && w_arready;
                if (w_rd) w_rnext = R_DATA;
            end
            R_DATA: if (i_rready) w_rnext = R_IDLE;
            default: w_rnext = R_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rstate <= R_IDLE;
            r_rresp  <= RESP_OKAY;
            r_roor   <= 1'b0;
        end else begin
            r_rstate <= w_rnext;
            if (w_rd) begin
                r_rresp <= w_roor ? RESP_SLVERR : RESP_OKAY;
                r_roor  <= w_roor;
            end
        end
    end

    axi_lite_dp_ram #(.RAW(RAW), .DEPTH(DEPTH)) u_ram (
        .clk     (clk),
        .i_we    (w_commit && !w_woor),
        .i_waddr (w_widx[RAW-1:0]),
        .i_wdata (w_wdata_sel),
        .i_wbe   (w_wstrb_sel),
        .i_re    (w_rd && !w_roor),
        .i_raddr (w_ridx[RAW-1:0]),
        .o_rdata (w_ram_rdata)
    );

    assign o_awready = w_awready;
    assign o_wready  = w_wready;
    assign o_bvalid  = (r_wstate == W_RESP);
    assign o_bresp   = r_bresp;
    assign o_arready = w_arready;
    assign o_rvalid  = (r_rstate == R_DATA);
    assign o_rlast   = o_rvalid;
    assign o_rresp   = r_rresp;
    assign o_rdata   = (o_rvalid && !r_roor) ? w_ram_rdata : 32'h0;
endmodule
